// File: rtl/bary_weight_unit.sv
// Barycentric weight generator: launches the area-reciprocal request for a triangle, then scales edge values by it.
// Optional macro BARY_SAT_EN: saturate each weight to 16 bits instead of two's-complement wrap.
module bary_weight_unit #(
  parameter int AREA_TIMEOUT = 64,
  parameter int FRAC_BITS    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic signed [15:0] v0x,
  input  logic signed [15:0] v0y,
  input  logic signed [15:0] v1x,
  input  logic signed [15:0] v1y,
  input  logic signed [15:0] v2x,
  input  logic signed [15:0] v2y,
  output logic               area_valid,
  output logic signed [15:0] area_v0x,
  output logic signed [15:0] area_v0y,
  output logic signed [15:0] area_v1x,
  output logic signed [15:0] area_v1y,
  output logic signed [15:0] area_v2x,
  output logic signed [15:0] area_v2y,
  input  logic               area_done,
  input  logic signed [15:0] area_recip,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic signed [15:0] e0,
  input  logic signed [15:0] e1,
  input  logic signed [15:0] e2,
  input  logic               pix_last,
  output logic               bary_valid,
  input  logic               bary_ready,
  output logic signed [15:0] l0,
  output logic signed [15:0] l1,
  output logic signed [15:0] l2,
  output logic               bary_last,
  output logic               area_err
);

  typedef enum logic [1:0] {IDLE, AREA_REQ, AREA_WAIT, PIX} state_t;

  localparam int CNT_W = $clog2(AREA_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AREA_TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic signed [15:0] recip_reg;
  logic               tri_acc, pix_acc, done_hit, timeout_hit;
  logic signed [15:0] e_vec [3];
  logic signed [15:0] w_vec [3];

  // tri_ready is masked by rst so it reads 0 in the reset cycle itself.
  assign tri_ready   = (state_reg == IDLE) && !rst;
  assign area_valid  = (state_reg == AREA_REQ);
  assign pix_ready   = (state_reg == PIX) && (!bary_valid || bary_ready);
  assign tri_acc     = tri_valid && tri_ready;
  assign pix_acc     = pix_valid && pix_ready;
  assign done_hit    = (state_reg == AREA_WAIT) && area_done;
  assign timeout_hit = (state_reg == AREA_WAIT) && !area_done && (cnt_reg == CNT_LAST);

  assign e_vec[0] = e0;
  assign e_vec[1] = e1;
  assign e_vec[2] = e2;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_weight
      logic signed [31:0] prod;
      assign prod = e_vec[gi] * recip_reg;
`ifdef BARY_SAT_EN
      logic signed [31:0] shifted;
      assign shifted = prod >>> FRAC_BITS;
      always_comb begin
        w_vec[gi] = shifted[15:0];
        if (shifted > 32'sd32767)
          w_vec[gi] = 16'sh7FFF;
        else if (shifted < -32'sd32768)
          w_vec[gi] = 16'sh8000;
      end
`else
      assign w_vec[gi] = 16'(prod >>> FRAC_BITS);
`endif
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (tri_acc) state_next = AREA_REQ;
      AREA_REQ:  state_next = AREA_WAIT;
      AREA_WAIT: if (done_hit || timeout_hit) state_next = PIX;
      PIX:       if (pix_acc && pix_last) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      recip_reg <= '0;
      area_err  <= 1'b0;
      area_v0x  <= '0;
      area_v0y  <= '0;
      area_v1x  <= '0;
      area_v1y  <= '0;
      area_v2x  <= '0;
      area_v2y  <= '0;
    end else begin
      state_reg <= state_next;
      if (tri_acc) begin
        area_v0x <= v0x;
        area_v0y <= v0y;
        area_v1x <= v1x;
        area_v1y <= v1y;
        area_v2x <= v2x;
        area_v2y <= v2y;
        area_err <= 1'b0;
      end
      if (state_reg == AREA_REQ)
        cnt_reg <= '0;
      else if (state_reg == AREA_WAIT)
        cnt_reg <= cnt_reg + CNT_W'(1);
      // A missing reciprocal degrades to zero weights so the pixel stream still drains.
      if (done_hit) begin
        recip_reg <= area_recip;
      end else if (timeout_hit) begin
        recip_reg <= '0;
        area_err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bary_valid <= 1'b0;
      bary_last  <= 1'b0;
      l0         <= '0;
      l1         <= '0;
      l2         <= '0;
    end else if (pix_acc) begin
      bary_valid <= 1'b1;
      bary_last  <= pix_last;
      l0         <= w_vec[0];
      l1         <= w_vec[1];
      l2         <= w_vec[2];
    end else if (bary_ready) begin
      bary_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bary_weight_unit.sv
// Scoreboard bench for bary_weight_unit: stimulus pushes expected weights, a monitor pops on each output handshake.
module tb_bary_weight_unit;

  localparam int FRAC = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tri_valid = 1'b0;
  logic tri_ready;
  logic signed [15:0] v0x = '0, v0y = '0, v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic area_valid;
  logic signed [15:0] area_v0x, area_v0y, area_v1x, area_v1y, area_v2x, area_v2y;
  logic area_done = 1'b0;
  logic signed [15:0] area_recip = '0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic signed [15:0] e0 = '0, e1 = '0, e2 = '0;
  logic pix_last = 1'b0;
  logic bary_valid;
  logic bary_ready;
  logic signed [15:0] l0, l1, l2;
  logic bary_last;
  logic area_err;

  bary_weight_unit #(.AREA_TIMEOUT(64), .FRAC_BITS(FRAC)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .area_valid(area_valid),
    .area_v0x(area_v0x), .area_v0y(area_v0y), .area_v1x(area_v1x),
    .area_v1y(area_v1y), .area_v2x(area_v2x), .area_v2y(area_v2y),
    .area_done(area_done), .area_recip(area_recip),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .e0(e0), .e1(e1), .e2(e2), .pix_last(pix_last),
    .bary_valid(bary_valid), .bary_ready(bary_ready),
    .l0(l0), .l1(l1), .l2(l2), .bary_last(bary_last), .area_err(area_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [15:0] c;
    logic               last;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cur_recip = 0;
  int   bp_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: floor((e*r) / 2^FRAC), then saturate or wrap into 16 bits.
  function automatic logic signed [15:0] ref_w(input int e, input int r);
    longint p, q, m;
    p = longint'(e) * longint'(r);
    q = p / (64'sd1 << FRAC);
    if ((p % (64'sd1 << FRAC)) != 0 && p < 0) q = q - 1;
`ifdef BARY_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
`else
    m = ((q % 65536) + 65536) % 65536;
    if (m >= 32768) m = m - 65536;
    return 16'(m);
`endif
  endfunction

  // Output-ready driver.
  initial begin
    bary_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       bary_ready = 1'b1;
        1:       bary_ready = ($urandom_range(0, 3) != 0);
        default: bary_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every handshaken output and checks hold behaviour under stall.
  exp_t held;
  bit   stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", bary_valid, 1);
        check("hold_data", {l0, l1, l2, bary_last}, held);
      end
      if (bary_valid && !bary_ready) check("stall_pix_ready", pix_ready, 0);
      if (bary_valid && bary_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("l0", l0, x.a);
          check("l1", l1, x.b);
          check("l2", l2, x.c);
          check("bary_last", bary_last, x.last);
        end
      end
      stalled = bary_valid && !bary_ready;
      held    = {l0, l1, l2, bary_last};
    end
  end

  // mode 0: area_done after 5 cycles; 1: never (timeout); 2: return while in AREA_WAIT.
  task automatic send_tri(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int mode, input int recip);
    int n;
    n = 0;
    @(negedge clk);
    while (!tri_ready && n < 300) begin @(negedge clk); n++; end
    check("tri_ready_wait", tri_ready, 1);
    v0x = 16'(x0); v0y = 16'(y0); v1x = 16'(x1); v1y = 16'(y1); v2x = 16'(x2); v2y = 16'(y2);
    tri_valid = 1'b1;
    @(posedge clk); #1;
    tri_valid = 1'b0;
    @(negedge clk);
    check("area_valid_pulse", area_valid, 1);
    check("tri_ready_busy", tri_ready, 0);
    check("area_err_clear", area_err, 0);
    check("area_vtx", {area_v0x, area_v0y, area_v1x, area_v1y, area_v2x, area_v2y},
          {16'(x0), 16'(y0), 16'(x1), 16'(y1), 16'(x2), 16'(y2)});
    @(posedge clk); #1;
    check("area_valid_single", area_valid, 0);
    if (mode == 0) begin
      repeat (3) @(posedge clk);
      #1;
      area_done = 1'b1; area_recip = 16'(recip);
      @(posedge clk); #1;
      area_done = 1'b0; area_recip = '0;
      cur_recip = recip;
    end else if (mode == 1) begin
      n = 0;
      while (!area_err && n < 100) begin @(posedge clk); #1; n++; end
      check("timeout_cycles", n, 64);
      check("area_err_set", area_err, 1);
      cur_recip = 0;
    end
  endtask

  task automatic send_pix(input int a, input int b, input int c, input bit last);
    int n;
    e0 = 16'(a); e1 = 16'(b); e2 = 16'(c); pix_last = last; pix_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      n++;
      if (n > 300) begin check("pix_accept_timeout", 0, 1); break; end
    end
    sb.push_back({ref_w(a, cur_recip), ref_w(b, cur_recip), ref_w(c, cur_recip), last});
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bary_valid) && n < 300) begin @(negedge clk); n++; end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tri_ready"}, tri_ready, 1);
    check({tag, "_area_valid"}, area_valid, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_bary_valid"}, bary_valid, 0);
    check({tag, "_l"}, {l0, l1, l2, bary_last}, 0);
    check({tag, "_area_err"}, area_err, 0);
    check({tag, "_area_vtx"}, {area_v0x, area_v0y, area_v1x, area_v1y, area_v2x, area_v2y}, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tri_ready", tri_ready, 0);
    check("rst_bary_valid", bary_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Basic path
    send_tri(0, 0, 256, 0, 0, 256, 0, 64);
    send_pix(256, 128, 0, 1);
    @(negedge clk);
    check("basic_latency_valid", bary_valid, 1);
    check("basic_l0", l0, 128);
    drain();

    // Backpressure: three stalled cycles inside a 4-pixel stream
    send_tri(10, 20, 30, 40, 50, 60, 0, 100);
    fork
      begin
        repeat (2) @(posedge clk);
        bp_mode = 2;
        repeat (3) @(posedge clk);
        bp_mode = 0;
      end
    join_none
    for (int i = 0; i < 4; i++) send_pix(100 * i + 7, -50 * i, 3 * i, i == 3);
    drain();

    // Timeout then recovery
    send_tri(1, 2, 3, 4, 5, 6, 1, 0);
    send_pix(100, -5, 7, 1);
    drain();
    send_tri(0, 0, 1, 1, 2, 2, 0, 32767);   // area_err_clear checked inside
    send_pix(32767, -32768, 1, 1);
    @(negedge clk);
`ifdef BARY_SAT_EN
    check("overflow_l0", l0, 32767);
`else
    check("overflow_l0", l0, -512);
`endif
    drain();

    // Negative values
    send_tri(0, 0, 0, 0, 0, 0, 0, 64);
    send_pix(-256, -1, 255, 1);
    drain();
    send_tri(0, 0, 0, 0, 0, 0, 0, 1);
    send_pix(-1, -128, 129, 1);
    @(negedge clk);
    check("neg_l0", l0, -1);
    drain();

    // Reset during AREA_WAIT, then a stray area_done
    send_tri(7, 7, 7, 7, 7, 7, 2, 0);
    repeat (3) @(posedge clk);
    pulse_reset();
    check_reset_outputs("rst_wait");
    #1 area_done = 1'b1; area_recip = 16'sd999;
    @(posedge clk); #1;
    area_done = 1'b0; area_recip = '0;
    @(negedge clk);
    check("stray_tri_ready", tri_ready, 1);
    check("stray_area_valid", area_valid, 0);
    check("stray_pix_ready", pix_ready, 0);

    // Reset during PIX with an output stalled
    bp_mode = 2;
    send_tri(3, 3, 3, 3, 3, 3, 0, 64);
    send_pix(128, 0, 0, 0);
    @(negedge clk);
    check("pix_stalled_valid", bary_valid, 1);
    pulse_reset();
    check_reset_outputs("rst_pix");
    bp_mode = 0;

    // Randomized triangles with random backpressure
    bp_mode = 1;
    for (int t = 0; t < 8; t++) begin
      int np, r;
      r  = int'($urandom_range(0, 8000)) - 4000;
      np = int'($urandom_range(1, 6));
      send_tri(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               (t == 5) ? 1 : 0, r);
      for (int p = 0; p < np; p++)
        send_pix(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, p == np - 1);
      drain();
    end
    bp_mode = 0;
    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bary_weight_unit.md
# bary_weight_unit

Triangle-side initiator for the area reciprocal unit, and per-pixel barycentric weight generator. It accepts one triangle's vertices and launches the reciprocal computation by driving the area unit's `valid_data`, vertex inputs and `area_done` interface. It waits for the result, latches the reciprocal, then scales a stream of per-pixel edge-function values into normalized barycentric weights for the shading stage. It sits between triangle setup (upstream) and the interpolator (downstream), with the area reciprocal unit as a side-attached peer.

## Interface
Parameters:
- `AREA_TIMEOUT`, default 64: maximum cycles spent in AREA_WAIT before giving up.
- `FRAC_BITS`, default 7: fractional bits of the Q-format. 1.0 = 128.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tri_valid` in 1: triangle offered.
- `tri_ready` out 1: high only in IDLE.
- `v0x`, `v0y`, `v1x`, `v1y`, `v2x`, `v2y` in 16 signed: triangle vertices, sampled when `tri_valid && tri_ready`.
- `area_valid` out 1: one-cycle pulse to the area unit's `valid_data`.
- `area_v0x` … `area_v2y` out 16 signed: registered vertex copies driven to the area unit.
- `area_done` in 1: one-cycle completion pulse from the area unit.
- `area_recip` in 16 signed: reciprocal, valid in the cycle `area_done` is high.
- `pix_valid`, `pix_ready` in/out 1: pixel handshake.
- `e0`, `e1`, `e2` in 16 signed: edge-function values.
- `pix_last` in 1: marks the final pixel of the triangle.
- `bary_valid`, `bary_ready` out/in 1: output handshake.
- `l0`, `l1`, `l2` out 16 signed: barycentric weights.
- `bary_last` out 1: accompanies the final weight set.
- `area_err` out 1: sticky. Set on timeout, cleared on the next triangle accept.

## Operation
States: IDLE, AREA_REQ, AREA_WAIT, PIX.

- **IDLE:** `tri_ready`=1. On `tri_valid`, register the vertices into `area_v*`, clear `area_err`, and go to AREA_REQ.
- **AREA_REQ:** `area_valid`=1 for exactly this one cycle. Load the timeout counter with 0. Go to AREA_WAIT.
- **AREA_WAIT:** the counter increments each cycle.
  - On `area_done`: latch `area_recip` into `recip_q` and go to PIX.
  - If the counter reaches `AREA_TIMEOUT-1` without `area_done`: set `recip_q`=0, set `area_err`=1, and go to PIX. The stream is consumed, never stalled forever.
- **PIX:** `pix_ready` = `!bary_valid || bary_ready`.
  - On accept, for each i: `l_i` = (`e_i` × `recip_q`) >>> `FRAC_BITS`. The product is a full 32-bit signed value; the shift is arithmetic. The 16-bit result is wrapped or saturated per Configuration.
  - `bary_last` <= `pix_last`.
  - When an accepted pixel has `pix_last`=1, go to IDLE in the next cycle. No further pixels are accepted for this triangle.
- `area_v*` hold stable from AREA_REQ through the `area_done` cycle. The area unit resamples vertices mid-computation.
- An `area_done` outside AREA_WAIT is ignored.
- `bary_valid`, `l*` and `bary_last` hold until `bary_ready`. If a new accept and a drain happen in the same cycle, the new data replaces the old with no gap.

## Timing
- Reset values: `tri_ready`=0 in the reset cycle and 1 from the first cycle after reset. `area_valid`=0, `area_v*`=0, `pix_ready`=0, `bary_valid`=0, `l0`/`l1`/`l2`=0, `bary_last`=0, `area_err`=0. `recip_q`=0, timeout counter=0, state=IDLE.
- Latency from triangle accept to `area_valid`: 1 cycle.
- With the standard area unit, `area_done` arrives 5 cycles after the `area_valid` edge. PIX is entered the cycle after `area_done`.
- Pixel throughput: 1 per cycle when `bary_ready`=1. Accept-to-`bary_valid` latency: 1 cycle.
- Reset mid-operation, in any state, returns to IDLE with all outputs at reset values. Any in-flight `area_done` is then ignored.
- `tri_valid` outside IDLE is ignored, and `tri_ready` stays 0.

## Configuration
- `BARY_SAT_EN` defined: each shifted product saturates to [-32768, 32767].
- `BARY_SAT_EN` undefined: the low 16 bits of the shifted product are taken (two's-complement wrap).
- All other behavior is identical in both builds.

## Test plan
- **Basic path:** triangle (0,0),(256,0),(0,256); model `area_done` 5 cycles after the pulse with `area_recip`=64; send pixel e=(256,128,0) -> l=(128,64,0), `bary_valid` 1 cycle after accept.
- **Backpressure:** with `bary_ready`=0 for 3 cycles during a 4-pixel stream -> `pix_ready` drops, outputs hold, no pixel lost or duplicated; `bary_last` only on the 4th.
- **Timeout:** never assert `area_done` -> after 64 cycles in AREA_WAIT `area_err`=1; pixel e=(100,-5,7) -> l=(0,0,0); the next `tri_valid` clears `area_err`.
- **Overflow:** e0=32767, `recip`=32767 -> `l0`=32767 with `BARY_SAT_EN`, `l0`=-512 without it.
- **Negative values:** e0=-256, `recip`=64 -> `l0`=-128. e0=-1, `recip`=1 -> `l0`=-1 (arithmetic shift).
- **Reset mid-triangle:** assert `rst` during AREA_WAIT and again in PIX -> next cycle all outputs are at reset values; a stray `area_done` afterwards causes no state change.
